// File: rtl/mem_test_ctrl_pkg.sv
// Shared definitions for the memory test controller: CSR word indices,
// test mode encoding, FSM states and the pattern generator used by both
// the command issuer and the read-back checker.
package mem_test_ctrl_pkg;

    // Parameter words (sys domain -> controller)
    localparam int CSR_TEST_PARAM  = 0;
    localparam int CSR_SET_ADDR    = 1;
    localparam int CSR_SET_COUNT   = 2;
    localparam int CSR_SET_DATA    = 3;

    // Result words (controller -> sys domain)
    localparam int CSR_TEST_RESULT = 0;
    localparam int CSR_ERR_CNT     = 1;
    localparam int CSR_ERR_ADDR    = 2;
    localparam int CSR_ERR_DATA    = 3;
    localparam int CSR_WR_REQ      = 4;
    localparam int CSR_RD_REQ      = 5;

    typedef enum logic [1:0] {
        MODE_WR_ONLY = 2'd0,
        MODE_RD_ONLY = 2'd1,
        MODE_WR_RD   = 2'd2,
        MODE_WR_RD_3 = 2'd3   // behaves exactly like MODE_WR_RD
    } test_mode_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        READ    = 3'd2,
        WAIT_RD = 3'd3,
        DONE    = 3'd4
    } state_e;

    // Data word for transaction idx; wraps modulo 2^32.
    function automatic logic [31:0] pattern_word(input logic [31:0] pattern,
                                                 input logic        inc,
                                                 input logic [31:0] idx);
        return inc ? (pattern + idx) : pattern;
    endfunction

endpackage

// File: rtl/mem_test_ctrl_if.sv
// Memory command / read-response bus between the test controller (master)
// and the memory under test (slave). Responses return in command order.
interface mem_test_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        rd_valid;
    logic [31:0] rd_data;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_data,
        input  cmd_ready, rd_valid, rd_data
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_data,
        output cmd_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/mem_test_cmp.sv
// Read-back checker: generates the expected word for each in-order
// response, counts mismatches, captures the first failing address/data and
// runs the read-response watchdog.
module mem_test_cmp
    import mem_test_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = 16
) (
    input  logic        clk_mem_i,
    input  logic        rst_n_i,
    input  logic        clear,        // start accepted: wipe all results
    input  logic        rd_phase,     // controller is in READ or WAIT_RD
    input  logic        read_entry,   // controller enters READ next cycle
    input  logic [31:0] rd_issued,    // read commands accepted so far
    input  logic [31:0] base,
    input  logic [31:0] pattern,
    input  logic        inc,
    input  logic [31:0] count,
    input  logic        rd_valid,
    input  logic [31:0] rd_data,
    output logic        all_rsp,
    output logic        wd_hit,
    output logic        timeout,
    output logic [31:0] err_cnt,
    output logic [31:0] err_addr,
    output logic [31:0] err_data
);

    localparam logic [TIMEOUT_W-1:0] WD_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    localparam logic [TIMEOUT_W-1:0] WD_MAX  = {TIMEOUT_W{1'b1}};

    logic [31:0]          rsp_cnt_reg;
    logic [TIMEOUT_W-1:0] wd_reg;
    logic                 timeout_reg;
    logic [31:0]          err_cnt_reg;
    logic [31:0]          err_addr_reg;
    logic [31:0]          err_data_reg;

    logic        outstanding;
    logic        rsp_take;
    logic        mismatch;
    logic        wd_run;
    logic [31:0] exp_data;

    // A response only counts if a read it could belong to is in flight.
    assign outstanding = (rsp_cnt_reg != rd_issued);
    assign rsp_take    = rd_valid && rd_phase && outstanding;
    assign exp_data    = pattern_word(pattern, inc, rsp_cnt_reg);
    assign mismatch    = rsp_take && (rd_data != exp_data);
    assign wd_run      = rd_phase && outstanding;
    // Fires on the edge at which the counter would reach its all-ones value.
    assign wd_hit      = wd_run && !rd_valid && !read_entry && (wd_reg == WD_LAST);
    assign all_rsp     = (rsp_cnt_reg == count);

    assign timeout  = timeout_reg;
    assign err_cnt  = err_cnt_reg;
    assign err_addr = err_addr_reg;
    assign err_data = err_data_reg;

    // Watchdog: restarted by any response or READ entry, counts while waiting.
    always_ff @(posedge clk_mem_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wd_reg      <= '0;
            timeout_reg <= 1'b0;
        end else if (clear) begin
            wd_reg      <= '0;
            timeout_reg <= 1'b0;
        end else begin
            if (rd_valid || read_entry) begin
                wd_reg <= '0;
            end else if (wd_run && (wd_reg != WD_MAX)) begin
                wd_reg <= wd_reg + WD_ONE;
            end
            if (wd_hit) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    // Response scoreboard: in-order index, saturating error count, first-error capture.
    always_ff @(posedge clk_mem_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_cnt_reg  <= '0;
            err_cnt_reg  <= '0;
            err_addr_reg <= '0;
            err_data_reg <= '0;
        end else if (clear) begin
            rsp_cnt_reg  <= '0;
            err_cnt_reg  <= '0;
            err_addr_reg <= '0;
            err_data_reg <= '0;
        end else if (rsp_take) begin
            rsp_cnt_reg <= rsp_cnt_reg + 32'd1;
            if (mismatch) begin
                if (err_cnt_reg != 32'hFFFF_FFFF) begin
                    err_cnt_reg <= err_cnt_reg + 32'd1;
                end
                if (err_cnt_reg == 32'd0) begin
                    err_addr_reg <= base + rsp_cnt_reg;
                    err_data_reg <= rd_data;
                end
            end
        end
    end

endmodule

// File: rtl/mem_test_ctrl.sv
// Memory test controller: on a start strobe latches the test parameters,
// issues N writes and/or N reads of a (optionally incrementing) pattern
// and reports pass/fail, error details and request counts.
module mem_test_ctrl
    import mem_test_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = 16
) (
    input  logic                                     clk_mem_i,
    input  logic                                     rst_n_i,
    input  logic                                     test_start_i,
    input  logic [CSR_SET_DATA:CSR_TEST_PARAM][31:0] test_param_i,
    output logic                                     test_finished_o,
    output logic [CSR_RD_REQ:CSR_TEST_RESULT][31:0]  test_result_o,
    mem_test_ctrl_if.master                          mem
);

    state_e      state_reg, state_next;
    test_mode_e  mode_reg;
    logic        inc_reg;
    logic [31:0] base_reg, count_reg, pattern_reg;
    logic [31:0] load_idx_reg, wr_req_reg, rd_req_reg;
    logic        cmd_valid_reg, cmd_write_reg;
    logic [31:0] cmd_addr_reg, cmd_data_reg;
    logic        finished_reg;

    logic        start_acc, cmd_fire, cmd_phase, rd_phase, read_entry, phase_end;
    logic        all_rsp, wd_hit, timeout_flag;
    logic [31:0] err_cnt, err_addr, err_data;
    logic        unused_param_bits;

    assign start_acc  = test_start_i && (state_reg == IDLE);
    assign cmd_fire   = cmd_valid_reg && mem.cmd_ready;
    assign cmd_phase  = (state_reg == WRITE) || (state_reg == READ);
    assign rd_phase   = (state_reg == READ) || (state_reg == WAIT_RD);
    assign read_entry = (state_next == READ) && (state_reg != READ);
    assign phase_end  = cmd_phase && (state_next != state_reg);
    assign unused_param_bits = ^test_param_i[CSR_TEST_PARAM][31:3];

    // State register.
    always_ff @(posedge clk_mem_i or negedge rst_n_i) begin
        if (!rst_n_i) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // Next-state logic; a zero count skips straight to DONE.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (test_start_i) begin
                    if (test_param_i[CSR_SET_COUNT] == 32'd0)
                        state_next = DONE;
                    else if (test_mode_e'(test_param_i[CSR_TEST_PARAM][1:0]) == MODE_RD_ONLY)
                        state_next = READ;
                    else
                        state_next = WRITE;
                end
            end
            WRITE: begin
                if (cmd_fire && (wr_req_reg + 32'd1 == count_reg))
                    state_next = (mode_reg == MODE_WR_ONLY) ? DONE : READ;
            end
            READ: begin
                if (wd_hit)
                    state_next = DONE;
                else if (cmd_fire && (rd_req_reg + 32'd1 == count_reg))
                    state_next = WAIT_RD;
            end
            WAIT_RD: begin
                if (wd_hit || all_rsp) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Parameter snapshot taken on the accepted start; ignored afterwards.
    always_ff @(posedge clk_mem_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mode_reg    <= MODE_WR_ONLY;
            inc_reg     <= 1'b0;
            base_reg    <= '0;
            count_reg   <= '0;
            pattern_reg <= '0;
        end else if (start_acc) begin
            mode_reg    <= test_mode_e'(test_param_i[CSR_TEST_PARAM][1:0]);
            inc_reg     <= test_param_i[CSR_TEST_PARAM][2];
            base_reg    <= test_param_i[CSR_SET_ADDR];
            count_reg   <= test_param_i[CSR_SET_COUNT];
            pattern_reg <= test_param_i[CSR_SET_DATA];
        end
    end

    // Command issuer: reloads the output register only when empty or just accepted.
    always_ff @(posedge clk_mem_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            load_idx_reg  <= '0;
            wr_req_reg    <= '0;
            rd_req_reg    <= '0;
            cmd_valid_reg <= 1'b0;
            cmd_write_reg <= 1'b0;
            cmd_addr_reg  <= '0;
            cmd_data_reg  <= '0;
        end else if (start_acc) begin
            load_idx_reg  <= '0;
            wr_req_reg    <= '0;
            rd_req_reg    <= '0;
            cmd_valid_reg <= 1'b0;
        end else begin
            if (cmd_fire) begin
                if (cmd_write_reg) wr_req_reg <= wr_req_reg + 32'd1;
                else               rd_req_reg <= rd_req_reg + 32'd1;
            end
            if (phase_end) begin
                load_idx_reg  <= '0;
                cmd_valid_reg <= 1'b0;
            end else if (cmd_phase && (!cmd_valid_reg || cmd_fire)) begin
                if (load_idx_reg != count_reg) begin
                    cmd_valid_reg <= 1'b1;
                    cmd_write_reg <= (state_reg == WRITE);
                    cmd_addr_reg  <= base_reg + load_idx_reg;
                    cmd_data_reg  <= pattern_word(pattern_reg, inc_reg, load_idx_reg);
                    load_idx_reg  <= load_idx_reg + 32'd1;
                end else begin
                    cmd_valid_reg <= 1'b0;
                end
            end
        end
    end

    // Finished flag: set entering DONE (wins over a same-cycle start), cleared by start.
    always_ff @(posedge clk_mem_i or negedge rst_n_i) begin
        if (!rst_n_i)                finished_reg <= 1'b0;
        else if (state_next == DONE) finished_reg <= 1'b1;
        else if (start_acc)          finished_reg <= 1'b0;
    end

    mem_test_cmp #(.TIMEOUT_W(TIMEOUT_W)) u_cmp (
        .clk_mem_i  (clk_mem_i),
        .rst_n_i    (rst_n_i),
        .clear      (start_acc),
        .rd_phase   (rd_phase),
        .read_entry (read_entry),
        .rd_issued  (rd_req_reg),
        .base       (base_reg),
        .pattern    (pattern_reg),
        .inc        (inc_reg),
        .count      (count_reg),
        .rd_valid   (mem.rd_valid),
        .rd_data    (mem.rd_data),
        .all_rsp    (all_rsp),
        .wd_hit     (wd_hit),
        .timeout    (timeout_flag),
        .err_cnt    (err_cnt),
        .err_addr   (err_addr),
        .err_data   (err_data)
    );

    assign mem.cmd_valid = cmd_valid_reg;
    assign mem.cmd_write = cmd_write_reg;
    assign mem.cmd_addr  = cmd_addr_reg;
    assign mem.cmd_data  = cmd_data_reg;

    assign test_finished_o = finished_reg;
    assign test_result_o[CSR_TEST_RESULT] = {30'd0, timeout_flag, timeout_flag || (err_cnt != 32'd0)};
    assign test_result_o[CSR_ERR_CNT]     = err_cnt;
    assign test_result_o[CSR_ERR_ADDR]    = err_addr;
    assign test_result_o[CSR_ERR_DATA]    = err_data;
    assign test_result_o[CSR_WR_REQ]      = wr_req_reg;
    assign test_result_o[CSR_RD_REQ]      = rd_req_reg;

endmodule

// File: tb/tb_mem_test_ctrl.sv
// Directed bench for mem_test_ctrl: a small memory model echoes written
// data one cycle after each read; each scenario checks the command stream
// and the result words against hand-computed values.
module tb_mem_test_ctrl;
    import mem_test_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 test_start;
    logic [3:0][31:0]     test_param;
    logic                 finished;
    logic [5:0][31:0]     result;

    mem_test_ctrl_if mem_if ();

    mem_test_ctrl #(.TIMEOUT_W(4)) dut (
        .clk_mem_i       (clk),
        .rst_n_i         (rst_n),
        .test_start_i    (test_start),
        .test_param_i    (test_param),
        .test_finished_o (finished),
        .test_result_o   (result),
        .mem             (mem_if)
    );

    int total = 0;
    int fails = 0;

    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] pend_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] rd_addr_q[$];
    int          done_cyc;
    int          rsp_last_cyc;
    logic        saw_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] prm, input logic [31:0] addr,
                            input logic [31:0] cnt, input logic [31:0] dat);
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        pend_q.delete();
        @(negedge clk);
        test_param[CSR_TEST_PARAM] = prm;
        test_param[CSR_SET_ADDR]   = addr;
        test_param[CSR_SET_COUNT]  = cnt;
        test_param[CSR_SET_DATA]   = dat;
        test_start = 1'b1;
        @(negedge clk);
        test_start = 1'b0;
    endtask

    // Cycle-by-cycle memory model; starts at the negedge after start acceptance.
    task automatic run_test(input bit toggle, input int resp_limit, input int bad_idx,
                            input logic [31:0] bad_data, input int start_cyc);
        int          cyc = 0;
        int          rsp_num = 0;
        bit          prev_stall = 0;
        logic        s_write = 1'b0;
        logic [31:0] s_addr = '0;
        logic [31:0] s_data = '0;
        logic [31:0] a;
        done_cyc     = -1;
        rsp_last_cyc = -1;
        saw_valid    = 1'b0;
        while (cyc < 300) begin
            cyc++;
            if (finished) begin
                done_cyc = cyc;
                break;
            end
            if (prev_stall) begin
                chk("hold_valid", {31'd0, mem_if.cmd_valid}, 32'd1);
                chk("hold_write", {31'd0, mem_if.cmd_write}, {31'd0, s_write});
                chk("hold_addr", mem_if.cmd_addr, s_addr);
                chk("hold_data", mem_if.cmd_data, s_data);
            end
            if (mem_if.cmd_valid) saw_valid = 1'b1;
            test_start = (cyc == start_cyc);
            if (cyc == start_cyc) begin
                test_param[CSR_SET_COUNT] = 32'd1;
                test_param[CSR_SET_ADDR]  = 32'd0;
            end
            mem_if.cmd_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            mem_if.rd_valid  = 1'b0;
            mem_if.rd_data   = '0;
            if (pend_q.size() > 0) begin
                a = pend_q.pop_front();
                if (rsp_num < resp_limit) begin
                    mem_if.rd_valid = 1'b1;
                    if (rsp_num == bad_idx)       mem_if.rd_data = bad_data;
                    else if (mem_model.exists(a)) mem_if.rd_data = mem_model[a];
                    else                          mem_if.rd_data = 32'd0;
                    rsp_last_cyc = cyc;
                end
                rsp_num++;
            end
            if (mem_if.cmd_valid && mem_if.cmd_ready) begin
                if (mem_if.cmd_write) begin
                    mem_model[mem_if.cmd_addr] = mem_if.cmd_data;
                    wr_addr_q.push_back(mem_if.cmd_addr);
                    wr_data_q.push_back(mem_if.cmd_data);
                end else begin
                    rd_addr_q.push_back(mem_if.cmd_addr);
                    pend_q.push_back(mem_if.cmd_addr);
                end
            end
            prev_stall = mem_if.cmd_valid && !mem_if.cmd_ready;
            s_write = mem_if.cmd_write;
            s_addr  = mem_if.cmd_addr;
            s_data  = mem_if.cmd_data;
            @(negedge clk);
        end
        test_start       = 1'b0;
        mem_if.cmd_ready = 1'b0;
        mem_if.rd_valid  = 1'b0;
        chk("finished", {31'd0, finished}, 32'd1);
    endtask

    task automatic chk_results(input string tag, input logic [31:0] tr, input logic [31:0] ec,
                               input logic [31:0] ea, input logic [31:0] ed,
                               input logic [31:0] wr, input logic [31:0] rd);
        chk({tag, "_result"},   result[CSR_TEST_RESULT], tr);
        chk({tag, "_err_cnt"},  result[CSR_ERR_CNT], ec);
        chk({tag, "_err_addr"}, result[CSR_ERR_ADDR], ea);
        chk({tag, "_err_data"}, result[CSR_ERR_DATA], ed);
        chk({tag, "_wr_req"},   result[CSR_WR_REQ], wr);
        chk({tag, "_rd_req"},   result[CSR_RD_REQ], rd);
    endtask

    task automatic chk_stream(input string tag, input int nwr, input int nrd,
                              input logic [31:0] base, input logic [31:0] pat, input bit inc);
        chk({tag, "_wr_cnt"}, 32'(wr_addr_q.size()), 32'(nwr));
        chk({tag, "_rd_cnt"}, 32'(rd_addr_q.size()), 32'(nrd));
        for (int i = 0; i < nwr; i++) begin
            chk({tag, "_wr_addr"}, wr_addr_q[i], base + 32'(i));
            chk({tag, "_wr_data"}, wr_data_q[i], inc ? pat + 32'(i) : pat);
        end
        for (int i = 0; i < nrd; i++) begin
            chk({tag, "_rd_addr"}, rd_addr_q[i], base + 32'(i));
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        test_start       = 1'b0;
        test_param       = '0;
        mem_if.cmd_ready = 1'b0;
        mem_if.rd_valid  = 1'b0;
        mem_if.rd_data   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_finished", {31'd0, finished}, 32'd0);
        chk("rst_cmd_valid", {31'd0, mem_if.cmd_valid}, 32'd0);
        for (int i = 0; i < 6; i++) chk("rst_result_word", result[i], 32'd0);

        // Write-then-read, incrementing pattern, perfect echo
        do_start(32'h6, 32'h100, 32'd4, 32'hA5A5_0000);
        run_test(1'b0, 99, -1, 32'd0, -1);
        chk_stream("wr_rd", 4, 4, 32'h100, 32'hA5A5_0000, 1'b1);
        chk_results("wr_rd", 32'd0, 32'd0, 32'd0, 32'd0, 32'd4, 32'd4);

        // Same, read index 2 corrupted; also checks the start clears results
        do_start(32'h6, 32'h100, 32'd4, 32'hA5A5_0000);
        chk("clr_finished", {31'd0, finished}, 32'd0);
        chk("clr_wr_req", result[CSR_WR_REQ], 32'd0);
        run_test(1'b0, 99, 2, 32'hDEAD_BEEF, -1);
        chk_results("bad_rd", 32'd1, 32'd1, 32'h102, 32'hDEAD_BEEF, 32'd4, 32'd4);

        // Write-only, fixed pattern, ready toggling every cycle
        do_start(32'h0, 32'h200, 32'd3, 32'h1234_5678);
        chk("clr_err_cnt", result[CSR_ERR_CNT], 32'd0);
        run_test(1'b1, 99, -1, 32'd0, -1);
        chk_stream("wr_only", 3, 0, 32'h200, 32'h1234_5678, 1'b0);
        chk_results("wr_only", 32'd0, 32'd0, 32'd0, 32'd0, 32'd3, 32'd0);

        // Read-only with one response missing: DONE 15 edges after the last response edge
        do_start(32'h1, 32'h300, 32'd2, 32'h0);
        run_test(1'b0, 1, -1, 32'd0, -1);
        chk("timeout_latency", 32'(done_cyc - rsp_last_cyc), 32'd16);
        chk_results("timeout", 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd2);
        // Stray response after the test must be ignored
        @(negedge clk);
        mem_if.rd_valid = 1'b1;
        mem_if.rd_data  = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_if.rd_valid = 1'b0;
        chk("stray_err_cnt", result[CSR_ERR_CNT], 32'd0);
        chk("stray_result", result[CSR_TEST_RESULT], 32'd3);
        chk("stray_finished", {31'd0, finished}, 32'd1);

        // Zero count: immediate DONE, no commands
        do_start(32'h2, 32'h500, 32'd0, 32'h0);
        run_test(1'b0, 99, -1, 32'd0, -1);
        chk("n0_latency", (done_cyc >= 1 && done_cyc <= 2) ? 32'd1 : 32'd0, 32'd1);
        chk("n0_no_cmd", {31'd0, saw_valid}, 32'd0);
        chk_results("n0", 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        // Asynchronous reset in the middle of WRITE
        do_start(32'h6, 32'h400, 32'd4, 32'h1111_0000);
        mem_if.cmd_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_wr_req", result[CSR_WR_REQ], 32'd1);
        chk("mid_cmd_valid", {31'd0, mem_if.cmd_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cmd_valid", {31'd0, mem_if.cmd_valid}, 32'd0);
        chk("arst_wr_req", result[CSR_WR_REQ], 32'd0);
        chk("arst_finished", {31'd0, finished}, 32'd0);
        @(negedge clk);
        mem_if.cmd_ready = 1'b0;
        rst_n = 1'b1;
        do_start(32'h6, 32'h100, 32'd4, 32'hA5A5_0000);
        run_test(1'b0, 99, -1, 32'd0, -1);
        chk_stream("post_rst", 4, 4, 32'h100, 32'hA5A5_0000, 1'b1);
        chk_results("post_rst", 32'd0, 32'd0, 32'd0, 32'd0, 32'd4, 32'd4);

        // Start (with altered parameters) pulsed during READ is ignored
        do_start(32'h5, 32'h100, 32'd3, 32'hA5A5_0000);
        run_test(1'b0, 99, -1, 32'd0, 2);
        chk_stream("rd_restart", 0, 3, 32'h100, 32'hA5A5_0000, 1'b1);
        chk_results("rd_restart", 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd3);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
